store_drain_queue: RTL and testbench

- Sits directly downstream of the commit stage and consumes its retired-store outputs: store_enable, store_mode, store_addr, store_data.
- Buffers committed stores in a small in-order FIFO.
- Converts each store to word-aligned byte-lane form.
- Drains stores one at a time to data memory over a req/ack handshake.
- Reports full to the buffer control so commit stalls store retirement.

---
 rtl/store_drain_queue_pkg.sv | 25 ++
 rtl/store_drain_queue_if.sv | 12 +
 rtl/store_drain_queue_lane_align.sv | 32 +++
 rtl/store_drain_queue.sv | 136 +++++++++++++
 tb/tb_store_drain_queue.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/store_drain_queue_pkg.sv
// Shared types for the store drain queue: store width modes, queue entry layout
// and drain FSM states.
package store_drain_queue_pkg;

  typedef logic bool;

  typedef enum logic [1:0] {
    MODE_SB = 2'd0,
    MODE_SH = 2'd1,
    MODE_SW = 2'd2
  } ldst_mode_t;

  // Entries hold the word address plus already lane-shifted data and strobes
  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sq_entry_t;

  typedef enum logic {
    D_IDLE,
    D_REQ
  } drain_state_t;

endpackage

// File: rtl/store_drain_queue_if.sv
// Data-memory write port used by the store drain queue (master) and the
// memory side (slave).
interface store_drain_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  modport master (output mem_req, mem_addr, mem_wdata, mem_wstrb, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_wdata, mem_wstrb, output mem_ack);
endinterface

// File: rtl/store_drain_queue_lane_align.sv
// Combinational store-width to byte-lane converter: produces strobes,
// replicated data and a misalignment flag from mode and low address bits.
module sq_lane_align import store_drain_queue_pkg::*; (
  input  ldst_mode_t  mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data_in,
  output logic [3:0]  strb,
  output logic [31:0] data_out,
  output bool         misaligned
);

  always_comb begin
    strb       = 4'b1111;
    data_out   = data_in;
    misaligned = 1'b0;
    case (mode)
      MODE_SB: begin
        strb     = 4'b0001 << addr_lo;
        data_out = {4{data_in[7:0]}};
      end
      MODE_SH: begin
        // Odd halfword addresses are flagged but still placed in the aligned half
        strb       = 4'b0011 << {addr_lo[1], 1'b0};
        data_out   = {2{data_in[15:0]}};
        misaligned = addr_lo[0];
      end
      MODE_SW: misaligned = (addr_lo != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/store_drain_queue.sv
// In-order committed-store FIFO draining to data memory over req/ack.
// Optional store-to-load forwarding lookup is enabled by defining STORE_FWD_EN.
module store_drain_queue import store_drain_queue_pkg::*; #(
  parameter int SQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  bool                  store_enable,
  input  ldst_mode_t           store_mode,
  input  logic [31:0]          store_addr,
  input  logic [31:0]          store_data,
  output bool                  sq_full,
  output bool                  sq_empty,
  output bool                  sq_err,
`ifdef STORE_FWD_EN
  input  logic [31:0]          ld_addr,
  output bool                  fwd_hit,
  output logic [31:0]          fwd_data,
  output bool                  fwd_block,
`endif
  store_drain_queue_if.master  mem
);

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  drain_state_t      state_reg, state_next;
  logic [PTR_W-1:0]  head_reg, head_next, tail_reg, tail_next, head_inc;
  logic [CNT_W-1:0]  count_reg, count_next;
  sq_entry_t         out_reg, out_next;
  logic              err_reg, err_next;
  sq_entry_t         entry_mem [SQ_DEPTH];

  logic [3:0]        al_strb;
  logic [31:0]       al_data;
  bool               al_mis;
  bool               enq, deq;

  sq_lane_align u_align (
    .mode       (store_mode),
    .addr_lo    (store_addr[1:0]),
    .data_in    (store_data),
    .strb       (al_strb),
    .data_out   (al_data),
    .misaligned (al_mis)
  );

  assign sq_full  = (count_reg == CNT_W'(SQ_DEPTH));
  assign sq_empty = (count_reg == '0);
  assign sq_err   = err_reg;
  // Fullness uses the registered count only, so an ack never frees a slot early
  assign enq      = store_enable && !sq_full;
  assign deq      = (state_reg == D_REQ) && mem.mem_ack;
  assign head_inc = head_reg + PTR_W'(1);

  assign mem.mem_req   = (state_reg == D_REQ);
  assign mem.mem_addr  = {out_reg.addr, 2'b00};
  assign mem.mem_wdata = out_reg.data;
  assign mem.mem_wstrb = out_reg.strb;

  always_ff @(posedge clk) begin
    if (enq) begin
      entry_mem[tail_reg] <= '{addr: store_addr[31:2], data: al_data, strb: al_strb};
    end
  end

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    out_next   = out_reg;
    err_next   = err_reg | (store_enable & (sq_full | al_mis));
    count_next = count_reg + CNT_W'(enq) - CNT_W'(deq);
    if (enq) tail_next = tail_reg + PTR_W'(1);
    case (state_reg)
      D_IDLE: begin
        if (count_reg != '0) begin
          out_next   = entry_mem[head_reg];
          state_next = D_REQ;
        end
      end
      D_REQ: begin
        if (mem.mem_ack) begin
          head_next = head_inc;
          if (count_reg > CNT_W'(1)) out_next = entry_mem[head_inc];
          else                       state_next = D_IDLE;
        end
      end
      default: state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= D_IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      out_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      out_reg   <= out_next;
      err_reg   <= err_next;
    end
  end

`ifdef STORE_FWD_EN
  // match indexed by age offset from head; the highest matching offset is youngest
  logic [SQ_DEPTH-1:0] fwd_match;
  logic [1:0]          unused_ld;
  assign unused_ld = ld_addr[1:0];

  for (genvar gi = 0; gi < SQ_DEPTH; gi++) begin : g_fwd
    assign fwd_match[gi] = (CNT_W'(gi) < count_reg) &&
                           (entry_mem[head_reg + PTR_W'(gi)].addr == ld_addr[31:2]);
  end

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_block = 1'b0;
    fwd_data  = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (fwd_match[i]) begin
        fwd_hit   = (entry_mem[head_reg + PTR_W'(i)].strb == 4'b1111);
        fwd_block = !fwd_hit;
        fwd_data  = fwd_hit ? entry_mem[head_reg + PTR_W'(i)].data : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_drain_queue.sv
// Directed self-checking bench for store_drain_queue; forwarding steps are
// included when STORE_FWD_EN is defined.
module tb_store_drain_queue;
  import store_drain_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bool         store_enable = 1'b0;
  ldst_mode_t  store_mode = MODE_SW;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;
  bool         sq_full, sq_empty, sq_err;
`ifdef STORE_FWD_EN
  logic [31:0] ld_addr = '0;
  bool         fwd_hit, fwd_block;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  store_drain_queue_if mem_bus ();

  store_drain_queue #(.SQ_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .store_enable (store_enable),
    .store_mode   (store_mode),
    .store_addr   (store_addr),
    .store_data   (store_data),
    .sq_full      (sq_full),
    .sq_empty     (sq_empty),
    .sq_err       (sq_err),
`ifdef STORE_FWD_EN
    .ld_addr      (ld_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .fwd_block    (fwd_block),
`endif
    .mem          (mem_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input ldst_mode_t m, input logic [31:0] a, input logic [31:0] d);
    store_enable = 1'b1;
    store_mode   = m;
    store_addr   = a;
    store_data   = d;
    tick();
    store_enable = 1'b0;
    $display("store mode=%0d addr=%h data=%h full=%0b err=%0b", m, a, d, sq_full, sq_err);
  endtask

  initial begin
    mem_bus.mem_ack = 1'b0;
    tick();
    tick();
    chk("rst_req",   32'(mem_bus.mem_req), 32'd0);
    chk("rst_addr",  mem_bus.mem_addr, 32'h0);
    chk("rst_strb",  32'(mem_bus.mem_wstrb), 32'h0);
    chk("rst_empty", 32'(sq_empty), 32'd1);
    chk("rst_full",  32'(sq_full), 32'd0);
    chk("rst_err",   32'(sq_err), 32'd0);
    rst_n = 1'b1;

    // SB to 0x1003, ack after two request cycles
    put(MODE_SB, 32'h1003, 32'h0000_00AB);
    chk("sb_latency_req", 32'(mem_bus.mem_req), 32'd0);
    chk("sb_not_empty",   32'(sq_empty), 32'd0);
    tick();
    chk("sb_req",   32'(mem_bus.mem_req), 32'd1);
    chk("sb_addr",  mem_bus.mem_addr, 32'h0000_1000);
    chk("sb_strb",  32'(mem_bus.mem_wstrb), 32'h8);
    chk("sb_wdata", mem_bus.mem_wdata, 32'hABAB_ABAB);
    tick();
    chk("sb_req_held", 32'(mem_bus.mem_req), 32'd1);
    chk("sb_addr_held", mem_bus.mem_addr, 32'h0000_1000);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    $display("write addr=00001000 acked");
    chk("sb_done_req",   32'(mem_bus.mem_req), 32'd0);
    chk("sb_done_empty", 32'(sq_empty), 32'd1);

    // Enqueue coinciding with the ack that retires the only entry
    put(MODE_SW, 32'h2000, 32'h5555_5555);
    tick();
    chk("sh_pre_req", 32'(mem_bus.mem_req), 32'd1);
    store_enable = 1'b1;
    store_mode   = MODE_SH;
    store_addr   = 32'h2002;
    store_data   = 32'h0000_1234;
    mem_bus.mem_ack = 1'b1;
    tick();
    store_enable = 1'b0;
    mem_bus.mem_ack = 1'b0;
    chk("sh_count_kept", 32'(sq_empty), 32'd0);
    chk("sh_not_full",   32'(sq_full), 32'd0);
    tick();
    chk("sh_req",   32'(mem_bus.mem_req), 32'd1);
    chk("sh_addr",  mem_bus.mem_addr, 32'h0000_2000);
    chk("sh_strb",  32'(mem_bus.mem_wstrb), 32'hC);
    chk("sh_wdata", mem_bus.mem_wdata, 32'h1234_1234);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("sh_empty", 32'(sq_empty), 32'd1);
    chk("sh_no_err", 32'(sq_err), 32'd0);

    // Misaligned word store
    put(MODE_SW, 32'h3001, 32'h0BAD_F00D);
    chk("sw_mis_err", 32'(sq_err), 32'd1);
    tick();
    chk("sw_mis_req",   32'(mem_bus.mem_req), 32'd1);
    chk("sw_mis_addr",  mem_bus.mem_addr, 32'h0000_3000);
    chk("sw_mis_strb",  32'(mem_bus.mem_wstrb), 32'hF);
    chk("sw_mis_wdata", mem_bus.mem_wdata, 32'h0BAD_F00D);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("sw_mis_empty", 32'(sq_empty), 32'd1);

    // Reset clears the sticky error
    rst_n = 1'b0;
    #1;
    chk("rst2_err",   32'(sq_err), 32'd0);
    chk("rst2_empty", 32'(sq_empty), 32'd1);
    tick();
    rst_n = 1'b1;

    // Fill with ack low, overflow, then drain back-to-back
    for (int i = 0; i < 4; i++) put(MODE_SW, 32'h100 + 32'(4 * i), 32'hA0A0_0000 + 32'(i));
    chk("ovf_full",   32'(sq_full), 32'd1);
    chk("ovf_req",    32'(mem_bus.mem_req), 32'd1);
    chk("ovf_no_err", 32'(sq_err), 32'd0);
    put(MODE_SW, 32'h200, 32'hFFFF_FFFF);
    chk("ovf_err",   32'(sq_err), 32'd1);
    chk("ovf_full2", 32'(sq_full), 32'd1);
    mem_bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_req",   32'(mem_bus.mem_req), 32'd1);
      chk("drain_addr",  mem_bus.mem_addr, 32'h100 + 32'(4 * i));
      chk("drain_wdata", mem_bus.mem_wdata, 32'hA0A0_0000 + 32'(i));
      tick();
      $display("write addr=%h acked", 32'h100 + 32'(4 * i));
    end
    mem_bus.mem_ack = 1'b0;
    chk("drain_done_req",   32'(mem_bus.mem_req), 32'd0);
    chk("drain_done_empty", 32'(sq_empty), 32'd1);

    // Ack while idle is ignored
    mem_bus.mem_ack = 1'b1;
    put(MODE_SW, 32'h600, 32'h0000_0600);
    chk("idle_ack_kept", 32'(sq_empty), 32'd0);
    tick();
    chk("idle_ack_req", 32'(mem_bus.mem_req), 32'd1);
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("idle_ack_empty", 32'(sq_empty), 32'd1);

    // Asynchronous reset with a request in flight
    put(MODE_SW, 32'h500, 32'h0000_0500);
    put(MODE_SW, 32'h504, 32'h0000_0504);
    put(MODE_SW, 32'h508, 32'h0000_0508);
    chk("inflight_req", 32'(mem_bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req",   32'(mem_bus.mem_req), 32'd0);
    chk("async_addr",  mem_bus.mem_addr, 32'h0);
    chk("async_wdata", mem_bus.mem_wdata, 32'h0);
    chk("async_strb",  32'(mem_bus.mem_wstrb), 32'h0);
    chk("async_empty", 32'(sq_empty), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_req",   32'(mem_bus.mem_req), 32'd0);
    chk("post_rst_empty", 32'(sq_empty), 32'd1);

`ifdef STORE_FWD_EN
    ld_addr = 32'h40;
    put(MODE_SW, 32'h40, 32'hDEAD_BEEF);
    put(MODE_SB, 32'h41, 32'h0000_0077);
    chk("fwd_block_sb", 32'(fwd_block), 32'd1);
    chk("fwd_hit_sb",   32'(fwd_hit), 32'd0);
    mem_bus.mem_ack = 1'b1;
    tick();
    chk("fwd_block_left", 32'(fwd_block), 32'd1);
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("fwd_none_hit",   32'(fwd_hit), 32'd0);
    chk("fwd_none_block", 32'(fwd_block), 32'd0);
    put(MODE_SB, 32'h41, 32'h0000_0077);
    put(MODE_SW, 32'h40, 32'hDEAD_BEEF);
    chk("fwd_hit",       32'(fwd_hit), 32'd1);
    chk("fwd_data",      fwd_data, 32'hDEAD_BEEF);
    chk("fwd_hit_block", 32'(fwd_block), 32'd0);
    mem_bus.mem_ack = 1'b1;
    tick();
    tick();
    mem_bus.mem_ack = 1'b0;
    chk("fwd_drained", 32'(sq_empty), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
